tap_frame_collector: RTL and testbench
======================================

Name: tap_frame_collector

Overview:
- Collects the serial, windowed IFFT fading-response samples (one complex sample per `dv_in`, tagged with its tap index) into a 32-entry frame.
- Presents each completed frame as a parallel tap vector for the complex convolver.
- Sits between the windower and the interpolator/convolver coefficient path.
- Double-buffered, so the downstream coefficients change atomically, only on frame boundaries, and never show a partially written frame.

Parameters:
- NTAPS, 32, taps per frame; power of two, at least 2.
- IW, 5, index width; equals log2(NTAPS).
- DW, 16, sample width of each real/imag component (two's complement).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dv_in  in  1  input sample valid.
- index_in  in  IW  tap index of the input sample.
- din_real  in  DW  input sample, real part.
- din_imag  in  DW  input sample, imaginary part.
- taps_real  out  NTAPS x DW  packed array; tap k = real coefficient k from the read bank.
- taps_imag  out  NTAPS x DW  packed array; tap k = imaginary coefficient k from the read bank.
- taps_valid  out  1  high once at least one complete frame has been published; sticky until reset.
- frame_strobe  out  1  one-cycle pulse in the cycle the read bank changes.
- seq_err  out  1  one-cycle pulse when an out-of-sequence index is seen.

Behaviour:
- Storage:
  - Two banks, A and B, each NTAPS x 2 x DW registers.
  - bank_sel selects the read bank; the other bank is the write bank.
  - taps_real and taps_imag are driven straight from the read-bank registers; no combinational path from the inputs.
- Sequencing:
  - Counter `expected` (IW bits) holds the next index accepted.
  - Frame FSM has two states, IDLE and FILL.
  - IDLE, `expected` = 0. On dv_in with index_in == 0: write sample to write bank[0], `expected` <= 1, go to FILL.
  - IDLE, dv_in with index_in != 0: sample dropped, no error raised; the block waits for frame start.
  - FILL, dv_in with index_in == `expected`: write to write bank[index_in], `expected` <= `expected` + 1.
  - FILL, accepted index == NTAPS-1: on the next clock edge bank_sel toggles, frame_strobe = 1 and taps_valid = 1; `expected` wraps to 0 and the FSM returns to IDLE.
  - FILL, dv_in with index_in != `expected`:
    - seq_err pulses in the next cycle and the partial frame is abandoned.
    - If index_in == 0, the sample is written to bank[0] and the FSM stays in FILL with `expected` = 1.
    - Otherwise the FSM goes to IDLE with `expected` = 0.
  - dv_in low: no state change. Gaps of any length inside a frame are legal.
- Latency: the last sample is accepted at edge N; new taps and frame_strobe are visible after edge N+1 (one cycle).
- Simultaneous events: a sample arriving in the cycle after the swap (index 0) starts the next frame normally into the new write bank. Throughput is one sample per cycle with no bubbles.
- Reset (applies at any time, including mid-frame):
  - bank_sel = 0, FSM = IDLE, `expected` = 0.
  - taps_valid, frame_strobe and seq_err all 0.
  - All bank registers cleared to 0, so taps_real and taps_imag read 0.
  - A partial frame in progress is discarded.
- Data is stored unmodified; no scaling or rounding.

Optional Feature:
- Macro: TAP_BITREV_ORDER_EN.
- When defined: the sequence check compares index_in against the bit-reversed value of `expected` (IW bits). The sample is written to the natural-order address, i.e. bank[index_in]. Frame completion triggers on the NTAPS-th accepted sample, when `expected` == NTAPS-1 before increment. Frame start still requires index_in == 0. This supports an IFFT configured for bit-reversed output.
- When undefined: strict ascending natural order as described above.

Test Plan:
- Reset, then a 32-sample frame at back-to-back cycles with index k, real = k, imag = -k → frame_strobe 1 cycle after index 31; taps_real[k] = k, taps_imag[k] = -k; taps_valid = 1; seq_err never asserts.
- A second frame with real = 100+k, sent with random dv_in gaps → taps hold frame-1 values until 1 cycle after index 31, then all 32 taps switch to 100+k in the same cycle.
- Indices 0..9 then 12 → seq_err pulse; no frame_strobe; taps unchanged. A following clean 0..31 frame is published correctly.
- Indices 0..15 then 0..31 → seq_err at the second 0; exactly one frame_strobe; published taps come from the 0..31 run.
- Reset asserted after index 20 of a frame → all outputs 0 on the next cycle. A subsequent 0..31 frame publishes, and taps_valid rises only then.
- With TAP_BITREV_ORDER_EN, indices sent in order 0,16,8,24,... carrying real = index → no seq_err; taps_real[k] = k after the strobe. Natural order 0,1,2 → seq_err at index 1.

Source files
------------

// File: rtl/tap_frame_collector.sv
// Double-buffered collector turning serial (index, I/Q) tap samples into a parallel tap frame.
// Optional build macro TAP_BITREV_ORDER_EN: expect taps in bit-reversed index order.
module tap_frame_collector #(
  parameter int NTAPS = 32,
  parameter int IW    = 5,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dv_in,
  input  logic [IW-1:0]       index_in,
  input  logic [DW-1:0]       din_real,
  input  logic [DW-1:0]       din_imag,
  output logic [NTAPS*DW-1:0] taps_real,
  output logic [NTAPS*DW-1:0] taps_imag,
  output logic                taps_valid,
  output logic                frame_strobe,
  output logic                seq_err
);

  // state | meaning
  // IDLE  | waiting for a sample with index 0 to open a frame
  // FILL  | frame open, accepting the next in-sequence index
  typedef enum logic {IDLE, FILL} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] expected_q, expected_d;
  logic [IW-1:0] match_idx;
  logic          bank_sel_q;
  logic          swap_pend_q, swap_pend_d;
  logic          seq_err_q, seq_err_d;
  logic          strobe_q;
  logic          valid_q;
  logic          wr_en;
  logic          wr_bank;

  logic [DW-1:0] bank_re_q [2][NTAPS];
  logic [DW-1:0] bank_im_q [2][NTAPS];

`ifdef TAP_BITREV_ORDER_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = v[IW-1-i];
    return r;
  endfunction
  assign match_idx = bitrev(expected_q);
`else
  assign match_idx = expected_q;
`endif

  // While a swap is pending, bank_sel still points at the old read bank,
  // which is about to become the write bank for a back-to-back frame.
  assign wr_bank = ~(bank_sel_q ^ swap_pend_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    swap_pend_d = 1'b0;
    seq_err_d   = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv_in && index_in == '0) begin
          wr_en      = 1'b1;
          expected_d = IW'(1);
          state_d    = FILL;
        end
      end
      FILL: begin
        if (dv_in) begin
          if (index_in == match_idx) begin
            wr_en = 1'b1;
            if (expected_q == IW'(NTAPS - 1)) begin
              expected_d  = '0;
              state_d     = IDLE;
              swap_pend_d = 1'b1;
            end else begin
              expected_d = expected_q + IW'(1);
            end
          end else begin
            seq_err_d = 1'b1;
            if (index_in == '0) begin
              wr_en      = 1'b1;
              expected_d = IW'(1);
            end else begin
              expected_d = '0;
              state_d    = IDLE;
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        expected_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      bank_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      seq_err_q   <= 1'b0;
      strobe_q    <= 1'b0;
      valid_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NTAPS; k++) begin
          bank_re_q[b][k] <= '0;
          bank_im_q[b][k] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      swap_pend_q <= swap_pend_d;
      seq_err_q   <= seq_err_d;
      strobe_q    <= swap_pend_q;
      if (swap_pend_q) begin
        bank_sel_q <= ~bank_sel_q;
        valid_q    <= 1'b1;
      end
      if (wr_en) begin
        bank_re_q[wr_bank][index_in] <= din_real;
        bank_im_q[wr_bank][index_in] <= din_imag;
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_taps
    assign taps_real[k*DW +: DW] = bank_re_q[bank_sel_q][k];
    assign taps_imag[k*DW +: DW] = bank_im_q[bank_sel_q][k];
  end

  assign taps_valid   = valid_q;
  assign frame_strobe = strobe_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_tap_frame_collector.sv
// Scoreboard bench for tap_frame_collector: expected frames/errors queued at drive time, checked at output.
module tb_tap_frame_collector;
  localparam int NTAPS = 32;
  localparam int IW    = 5;
  localparam int DW    = 16;
  localparam int TW    = NTAPS * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dv_in = 1'b0;
  logic [IW-1:0] index_in = '0;
  logic [DW-1:0] din_real = '0;
  logic [DW-1:0] din_imag = '0;
  logic [TW-1:0] taps_real, taps_imag;
  logic          taps_valid, frame_strobe, seq_err;

  tap_frame_collector #(.NTAPS(NTAPS), .IW(IW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .index_in(index_in),
    .din_real(din_real), .din_imag(din_imag),
    .taps_real(taps_real), .taps_imag(taps_imag),
    .taps_valid(taps_valid), .frame_strobe(frame_strobe), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int            due;
    logic [TW-1:0] re;
    logic [TW-1:0] im;
  } frame_t;

  frame_t        fq[$];
  int            sq[$];
  logic [TW-1:0] pub_re = '0, pub_im = '0;
  logic          pub_valid = 1'b0;

  logic [DW-1:0] part_re [NTAPS];
  logic [DW-1:0] part_im [NTAPS];
  bit            m_fill = 1'b0;
  int            m_exp  = 0;

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int br5(input int v);
    int r = 0;
    for (int i = 0; i < IW; i++) if (v[i]) r |= 1 << (IW - 1 - i);
    return r;
  endfunction

  function automatic int ref_idx(input int e);
`ifdef TAP_BITREV_ORDER_EN
    return br5(e);
`else
    return e;
`endif
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_strobe, exp_se;
      exp_strobe = (fq.size() > 0) && (fq[0].due == cyc);
      exp_se     = (sq.size() > 0) && (sq[0] == cyc);
      if (exp_strobe) begin
        pub_re    = fq[0].re;
        pub_im    = fq[0].im;
        pub_valid = 1'b1;
        void'(fq.pop_front());
      end
      if (exp_se) void'(sq.pop_front());
      chk("frame_strobe", TW'(frame_strobe), TW'(exp_strobe));
      chk("seq_err", TW'(seq_err), TW'(exp_se));
      chk("taps_valid", TW'(taps_valid), TW'(pub_valid));
      chk("taps_real", taps_real, pub_re);
      chk("taps_imag", taps_imag, pub_im);
    end
  end

  task automatic send(input int idx, input int re, input int im);
    logic [TW-1:0] fr, fi;
    @(negedge clk);
    dv_in    = 1'b1;
    index_in = IW'(idx);
    din_real = DW'(re);
    din_imag = DW'(im);
    if (!m_fill) begin
      if (idx == 0) begin
        part_re[0] = DW'(re); part_im[0] = DW'(im);
        m_exp = 1; m_fill = 1'b1;
      end
    end else if (idx == ref_idx(m_exp)) begin
      part_re[idx] = DW'(re); part_im[idx] = DW'(im);
      if (m_exp == NTAPS - 1) begin
        for (int k = 0; k < NTAPS; k++) begin
          fr[k*DW +: DW] = part_re[k];
          fi[k*DW +: DW] = part_im[k];
        end
        fq.push_back('{due: cyc + 2, re: fr, im: fi});
        m_fill = 1'b0; m_exp = 0;
      end else begin
        m_exp++;
      end
    end else begin
      sq.push_back(cyc + 1);
      if (idx == 0) begin
        part_re[0] = DW'(re); part_im[0] = DW'(im);
        m_exp = 1;
      end else begin
        m_fill = 1'b0; m_exp = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dv_in = 1'b0;
    @(posedge clk);
    #1;
    fq.delete(); sq.delete();
    pub_re = '0; pub_im = '0; pub_valid = 1'b0;
    m_fill = 1'b0; m_exp = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    do_reset();
    chk("rst_taps_valid", TW'(taps_valid), '0);
    chk("rst_taps_real", taps_real, '0);

    for (int k = 0; k < NTAPS; k++) send(k, k, -k);
    for (int k = 0; k < NTAPS; k++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send(k, 100 + k, 3 * k + 7);
    end
    idle(3);

    for (int k = 0; k < 10; k++) send(k, 500 + k, k);
    send(12, 512, 12);
    idle(2);
    for (int k = 0; k < NTAPS; k++) send(k, 200 + k, -2 * k);
    for (int k = 0; k < 16; k++) send(k, 700 + k, 1);
    for (int k = 0; k < NTAPS; k++) send(k, 300 + k, k ^ 5);
    idle(3);

    for (int k = 0; k <= 20; k++) send(k, 900 + k, k);
    do_reset();
    chk("midrst_valid", TW'(taps_valid), '0);
    chk("midrst_real", taps_real, '0);
    chk("midrst_imag", taps_imag, '0);
    for (int k = 0; k < NTAPS; k++) send(k, 40 + k, 60 - k);
    idle(3);

    for (int k = 0; k < NTAPS; k++) send(br5(k), br5(k), k);
    idle(2);
    for (int k = 0; k < 3; k++) send(k, 11, 22);
    idle(4);

    chk("sb_frames_left", TW'(fq.size()), '0);
    chk("sb_errs_left", TW'(sq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
